// File: rtl/sr_ctrl_pkg.sv
// sr_ctrl_pkg: shared FSM encoding and default timing for sr_pulse_ctrl
package sr_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PULSE_CYCLES = 2;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, debounce counter and registered rising-edge strobe
module btn_debounce
  import sr_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_d;
  logic             r_rise;

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
      if (r_sync[1] == r_level) r_cnt <= '0;
      else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end

  assign o_level = r_level;
  assign o_rise  = r_rise;
endmodule

// File: rtl/sr_pulse_ctrl.sv
// sr_pulse_ctrl: turns two raw buttons into mutually exclusive set/reset pulses for sr_latch
module sr_pulse_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_set_btn,
  input  logic i_reset_btn,
  output logic o_s,
  output logic o_r,
  output logic o_busy,
  output logic o_conflict
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES > PULSE_CYCLES ? DEBOUNCE_CYCLES : PULSE_CYCLES) + 1;

  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_pcnt;
  logic             r_pend_s, r_pend_r, r_s, r_r, r_busy, r_conflict;
  logic [1:0]       w_rise, w_unused_lvl;
  logic             w_idle, w_req_s, w_req_r, w_conflict, w_last, w_pend_s, w_pend_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_set (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_set_btn), .o_level(w_unused_lvl[0]), .o_rise(w_rise[0])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_reset (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_reset_btn), .o_level(w_unused_lvl[1]), .o_rise(w_rise[1])
  );

  // Reset wins in IDLE; a set that arrives alongside a new reset is dropped, an older pending set survives
  always_comb begin
    w_idle     = r_state == IDLE;
    w_req_r    = w_rise[1] | r_pend_r;
    w_req_s    = w_rise[0] | r_pend_s;
    w_conflict = w_idle & w_rise[1] & w_rise[0];
    w_last     = r_pcnt == CNT_W'(PULSE_CYCLES - 1);
    w_nxt      = w_idle ? (w_req_r ? PULSE_R : w_req_s ? PULSE_S : IDLE)
               : r_state == GAP ? IDLE : w_last ? GAP : r_state;
    w_pend_r   = ~w_idle & (r_pend_r | w_rise[1]);
    w_pend_s   = w_idle ? w_req_r & (r_pend_s | (w_rise[0] & ~w_rise[1])) : r_pend_s | w_rise[0];
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state    <= IDLE;
      r_pcnt     <= '0;
      r_pend_s   <= 1'b0;
      r_pend_r   <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_pcnt     <= (w_nxt == r_state && !w_idle) ? r_pcnt + 1'b1 : '0;
      r_pend_s   <= w_pend_s;
      r_pend_r   <= w_pend_r;
      r_s        <= w_nxt == PULSE_S;
      r_r        <= w_nxt == PULSE_R;
      r_busy     <= w_nxt != IDLE;
      r_conflict <= w_conflict;
    end

  assign o_s        = r_s;
  assign o_r        = r_r;
  assign o_busy     = r_busy;
  assign o_conflict = r_conflict;
endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// tb_sr_pulse_ctrl: directed scenarios plus random button bounce against a countdown-based model
module tb_sr_pulse_ctrl;
  localparam int DEB = 4;
  localparam int PUL = 2;

  logic clk = 1'b0, rst = 1'b1, set_btn = 1'b0, reset_btn = 1'b0;
  logic o_s, o_r, o_busy, o_conflict;
  int checks = 0, errors = 0;

  sr_pulse_ctrl #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL)) dut (
    .i_clk(clk), .i_rst(rst), .i_set_btn(set_btn), .i_reset_btn(reset_btn),
    .o_s(o_s), .o_r(o_r), .o_busy(o_busy), .o_conflict(o_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: delay lines for sync and strobe, run-length debounce, countdown scheduler
  bit m_sy0[2], m_sy1[2], m_deb[2], m_d1[2], m_d2[2], m_use[2];
  int m_run[2];
  bit m_ps, m_pr, m_kind_r;
  int m_left;
  bit e_s, e_r, e_busy, e_conf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_sy0[b] = 0; m_sy1[b] = 0; m_deb[b] = 0; m_d1[b] = 0; m_d2[b] = 0; m_use[b] = 0; m_run[b] = 0;
      end
      m_ps = 0; m_pr = 0; m_kind_r = 0; m_left = 0;
      e_s = 0; e_r = 0; e_busy = 0; e_conf = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        bit s;
        m_use[b] = m_d2[b];
        m_d2[b] = m_d1[b];
        m_d1[b] = 0;
        s = m_sy1[b];
        m_sy1[b] = m_sy0[b];
        m_sy0[b] = (b == 0) ? set_btn : reset_btn;
        if (s != m_deb[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_deb[b] = s;
            m_run[b] = 0;
            m_d1[b] = s;
          end
        end else m_run[b] = 0;
      end
      e_conf = 0;
      if (m_left > 0) begin
        m_left--;
        m_ps |= m_use[0];
        m_pr |= m_use[1];
      end else if (m_use[1] || m_pr) begin
        e_conf = m_use[0] & m_use[1];
        m_ps = m_ps | (m_use[0] & !m_use[1]);
        m_pr = 0;
        m_kind_r = 1;
        m_left = PUL + 1;
      end else if (m_use[0] || m_ps) begin
        m_ps = 0;
        m_kind_r = 0;
        m_left = PUL + 1;
      end
      e_s = !m_kind_r && m_left > 1;
      e_r = m_kind_r && m_left > 1;
      e_busy = m_left > 0;
    end
  end

  always @(negedge clk) begin
    chk("cmp_s", o_s, e_s);
    chk("cmp_r", o_r, e_r);
    chk("cmp_busy", o_busy, e_busy);
    chk("cmp_conflict", o_conflict, e_conf);
    chk("inv_s_and_r", o_s & o_r, 0);
  end

  int n_s = 0, n_r = 0, n_busy = 0;
  logic p_s = 1'b0, p_r = 1'b0;
  always @(negedge clk) begin
    if (o_s && !p_s) n_s++;
    if (o_r && !p_r) n_r++;
    if (o_busy) n_busy++;
    p_s = o_s;
    p_r = o_r;
  end

  logic lq = 1'b0;
  always @(o_s or o_r) if (o_s) lq = 1'b1; else if (o_r) lq = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    repeat (3) @(negedge clk);
    chk("rst_xfree", int'($isunknown({o_s, o_r, o_busy, o_conflict})), 0);
    chk("rst_s", o_s, 0);
    chk("rst_r", o_r, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_conflict", o_conflict, 0);
    rst = 1'b0;
    b = n_busy;
    repeat (20) @(negedge clk);
    chk("idle_quiet", n_busy - b, 0);

    set_btn = 1'b1;
    repeat (8) @(negedge clk);
    chk("clean_s_e7", o_s, 1);
    chk("clean_busy_e7", o_busy, 1);
    @(negedge clk);
    chk("clean_s_e8", o_s, 1);
    @(negedge clk);
    chk("clean_s_e9", o_s, 0);
    chk("clean_busy_e9", o_busy, 1);
    @(negedge clk);
    chk("clean_busy_e10", o_busy, 0);
    chk("latch_q_set", lq, 1);
    set_btn = 1'b0;
    repeat (20) @(negedge clk);

    b = n_s;
    for (int k = 0; k < 4; k++) begin
      set_btn = 1'b1;
      repeat (3) @(negedge clk);
      set_btn = 1'b0;
      repeat (2) @(negedge clk);
    end
    set_btn = 1'b1;
    repeat (7) @(negedge clk);
    chk("bounce_s_e6", o_s, 0);
    @(negedge clk);
    chk("bounce_s_e7", o_s, 1);
    repeat (10) @(negedge clk);
    chk("bounce_one_pulse", n_s - b, 1);
    set_btn = 1'b0;
    repeat (20) @(negedge clk);

    b = n_s;
    set_btn = 1'b1;
    reset_btn = 1'b1;
    repeat (8) @(negedge clk);
    chk("simul_conflict_e7", o_conflict, 1);
    chk("simul_r_e7", o_r, 1);
    @(negedge clk);
    chk("simul_conflict_e8", o_conflict, 0);
    chk("simul_r_e8", o_r, 1);
    repeat (15) @(negedge clk);
    chk("simul_no_s", n_s - b, 0);
    chk("latch_q_reset", lq, 0);
    set_btn = 1'b0;
    reset_btn = 1'b0;
    repeat (20) @(negedge clk);

    set_btn = 1'b1;
    @(negedge clk);
    reset_btn = 1'b1;
    repeat (3) @(negedge clk);
    set_btn = 1'b0;
    repeat (4) @(negedge clk);
    chk("pend_s_e7", o_s, 1);
    set_btn = 1'b1;
    repeat (4) @(negedge clk);
    chk("pend_r_e11", o_r, 1);
    @(negedge clk);
    chk("pend_r_e12", o_r, 1);
    @(negedge clk);
    chk("pend_r_e13", o_r, 0);
    repeat (2) @(negedge clk);
    chk("pend_s_e15", o_s, 1);
    set_btn = 1'b0;
    reset_btn = 1'b0;
    repeat (20) @(negedge clk);

    reset_btn = 1'b1;
    for (int k = 0; k < 40 && !o_r; k++) @(negedge clk);
    chk("mid_r_seen", o_r, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_r_drop", o_r, 0);
    chk("mid_busy_drop", o_busy, 0);
    reset_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b = n_r + n_s;
    repeat (30) @(negedge clk);
    chk("mid_no_resume", n_r + n_s - b, 0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) set_btn = ~set_btn;
      if ($urandom_range(7) == 0) reset_btn = ~reset_btn;
      #2 rst = ($urandom_range(999) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    set_btn = 1'b1;
    reset_btn = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b = n_s;
    repeat (30) @(negedge clk);
    chk("held_through_reset", n_s - b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
